spi_cmd_master: RTL and testbench

- Read-side consumer of the AHB-to-SPI async FIFO, clocked in the SPI (read) clock domain.
- Pops one 41-bit command word at a time and runs one SPI mode-0 frame per word.
- For read commands it captures a 32-bit response from MISO and presents it with a one-cycle valid strobe.

---
 rtl/spi_cmd_master.sv | 158 +++++++++++++++
 tb/tb_spi_cmd_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: pops {rw, addr, data} words from the FIFO read side and runs one CS_n frame per word.
// Define SPI_CS_GAP_EN to add a GAP state that holds spi_cs_n high for CS_GAP cycles after each frame.
module spi_cmd_master #(
  parameter int DATA_WIDTH = 41,
  parameter int ADDR_BITS  = 8,
  parameter int WORD_BITS  = 32,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_cs_n,
  output logic [WORD_BITS-1:0]  rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int HDR_BITS = 1 + ADDR_BITS;
  localparam int CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
`ifdef SPI_CS_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [5:0]            bit_cnt;
  logic [DATA_WIDTH-2:0] tx_shift;
  logic [WORD_BITS-1:0]  rx_shift;
  logic                  rw;
  logic                  div_tc;
  logic                  frame_end;

  assign div_tc    = (cnt == DIV_LAST);
  // Last falling SCLK edge: all DATA_WIDTH rising edges already counted.
  assign frame_end = div_tc && spi_sclk && (bit_cnt == 6'(DATA_WIDTH));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      S_IDLE:  if (!fifo_empty) next_state = S_FETCH;
      S_FETCH: next_state = S_LOAD;
      S_LOAD:  next_state = S_SETUP;
      S_SETUP: if (div_tc) next_state = S_SHIFT;
      S_SHIFT: if (frame_end) next_state = S_HOLD;
`ifdef SPI_CS_GAP_EN
      S_HOLD:  if (div_tc) next_state = S_GAP;
      S_GAP:   if (cnt == GAP_LAST) next_state = S_IDLE;
`else
      S_HOLD:  if (div_tc) next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs; the pop is gated by rst_n so no word is lost while reset is held.
  always_comb begin
    fifo_rd_en = (state == S_IDLE) && !fifo_empty && rst_n;
    busy       = (state != S_IDLE);
    spi_cs_n   = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));
  end

  // Divider, bit counter, shift registers and registered SPI outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, so no X reaches spi_mosi or rx_data after reset.
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rw       <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          tx_shift <= fifo_rd_data[DATA_WIDTH-2:0];
          rw       <= fifo_rd_data[DATA_WIDTH-1];
          spi_mosi <= fifo_rd_data[DATA_WIDTH-1];
          bit_cnt  <= '0;
          cnt      <= '0;
        end
        S_SETUP: begin
          cnt <= div_tc ? '0 : cnt + 1'b1;
        end
        S_SHIFT: begin
          if (div_tc) begin
            cnt      <= '0;
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              // Rising edge: bit_cnt is the index of the bit being sampled.
              bit_cnt <= bit_cnt + 1'b1;
              if (!rw && (bit_cnt >= 6'(HDR_BITS)))
                rx_shift <= {rx_shift[WORD_BITS-2:0], spi_miso};
            end else begin
              // Falling edge: present bit index bit_cnt; read data phase drives zeros.
              tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
              spi_mosi <= (rw || (bit_cnt < 6'(HDR_BITS))) ? tx_shift[DATA_WIDTH-2] : 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (div_tc) begin
            cnt      <= '0;
            spi_mosi <= 1'b0;
            if (!rw) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SPI_CS_GAP_EN
        S_GAP: begin
          cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
        end
`endif
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master (CLK_DIV=2): FIFO model, mode-0 slave model, frame monitor and vector table.
module tb_spi_cmd_master;

  localparam int DW = 41;
`ifdef SPI_CS_GAP_EN
  localparam int EXP_GAP = 4;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso;
  logic          spi_cs_n;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          busy;

  spi_cmd_master #(.CLK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs_n     (spi_cs_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle read latency; output holds until the next pop.
  logic [DW-1:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Slave: presents bit index fall_cnt (changed after each falling SCLK), response in bits 9..40.
  logic [31:0] slave_resp = '0;
  int          fall_cnt   = 0;
  always_comb begin
    spi_miso = 1'b0;
    if (!spi_cs_n && fall_cnt >= 9 && fall_cnt <= 40)
      spi_miso = slave_resp[5'(40 - fall_cnt)];
  end

  // Monitor on the falling clk edge: frames, pops and rx_valid pulses.
  logic          sclk_d = 1'b0;
  logic          cs_d   = 1'b1;
  int            cyc    = 0;
  int            frames = 0;
  int            pops   = 0;
  int            rxv_cnt = 0;
  int            rxv_bad_align = 0;
  int            rise_cnt_cur = 0;
  int            cs_len_cur = 0;
  int            cur_fall_cyc = 0;
  logic [DW-1:0] mosi_cur = '0;
  logic [DW-1:0] fr_mosi [32];
  int            fr_rises [32];
  int            fr_len [32];
  int            fr_fall_cyc [32];
  int            fr_rise_cyc [32];
  int            pop_cyc [32];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_d <= spi_sclk;
    cs_d   <= spi_cs_n;
    if (fifo_rd_en === 1'b1) begin
      if (pops < 32) pop_cyc[pops] <= cyc;
      pops <= pops + 1;
    end
    if (rx_valid === 1'b1) begin
      rxv_cnt <= rxv_cnt + 1;
      if (!(spi_cs_n === 1'b1 && cs_d === 1'b0)) rxv_bad_align <= rxv_bad_align + 1;
    end
    if (spi_cs_n !== 1'b0) begin
      fall_cnt <= 0;
      if (cs_d === 1'b0) begin
        if (frames < 32) begin
          fr_mosi[frames]     <= mosi_cur;
          fr_rises[frames]    <= rise_cnt_cur;
          fr_len[frames]      <= cs_len_cur;
          fr_fall_cyc[frames] <= cur_fall_cyc;
          fr_rise_cyc[frames] <= cyc;
        end
        frames <= frames + 1;
      end
    end else if (cs_d === 1'b1) begin
      cur_fall_cyc <= cyc;
      cs_len_cur   <= 1;
      rise_cnt_cur <= 0;
      mosi_cur     <= '0;
    end else begin
      cs_len_cur <= cs_len_cur + 1;
      if (spi_sclk === 1'b1 && sclk_d === 1'b0) begin
        rise_cnt_cur <= rise_cnt_cur + 1;
        mosi_cur     <= {mosi_cur[DW-2:0], spi_mosi};
      end
      if (spi_sclk === 1'b0 && sclk_d === 1'b1) fall_cnt <= fall_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int k = 0;
    while (frames < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(frames >= target), 64'd1);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic [31:0]   resp;
    logic [DW-1:0] exp_mosi;
    int            exp_rxv;
    logic [31:0]   exp_rx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;
    int bf;
    int bp;
    int brx;
    int k;

    vecs[0] = '{41'h1_A5_DEADBEEF, 32'hFFFFFFFF, 41'h1_A5_DEADBEEF, 0, 32'h00000000};
    vecs[1] = '{41'h0_3C_00000000, 32'h12345678, 41'h0_3C_00000000, 1, 32'h12345678};
    vecs[2] = '{41'h0_81_FFFFFFFF, 32'hA5A50F0F, 41'h0_81_00000000, 1, 32'hA5A50F0F};
    vecs[3] = '{41'h1_00_00000001, 32'hFFFFFFFF, 41'h1_00_00000001, 0, 32'hA5A50F0F};
    vecs[4] = '{41'h1_FF_80000000, 32'h00000000, 41'h1_FF_80000000, 0, 32'hA5A50F0F};
    vecs[5] = '{41'h0_FF_12345678, 32'h80000001, 41'h0_FF_00000000, 1, 32'h80000001};

    // Reset values, then a long quiet period with the FIFO empty
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",     64'(spi_cs_n),   64'd1);
    check("rst_sclk",     64'(spi_sclk),   64'd0);
    check("rst_mosi",     64'(spi_mosi),   64'd0);
    check("rst_rd_en",    64'(fifo_rd_en), 64'd0);
    check("rst_rx_data",  64'(rx_data),    64'd0);
    check("rst_rx_valid", 64'(rx_valid),   64'd0);
    check("rst_busy",     64'(busy),       64'd0);
    rst_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("idle_quiet_violations", 64'(viol), 64'd0);
    check("idle_no_pops", 64'(pops), 64'd0);

    // Single-frame vectors
    for (int i = 0; i < 6; i++) begin
      bf  = frames;
      bp  = pops;
      brx = rxv_cnt;
      slave_resp = vecs[i].resp;
      @(posedge clk);
      #1 push(vecs[i].word);
      wait_frames(bf + 1, 400, $sformatf("v%0d_frame_done", i));
      @(negedge clk);
      check($sformatf("v%0d_pops", i),    64'(pops - bp),        64'd1);
      check($sformatf("v%0d_mosi", i),    64'(fr_mosi[bf]),      64'(vecs[i].exp_mosi));
      check($sformatf("v%0d_rises", i),   64'(fr_rises[bf]),     64'd41);
      check($sformatf("v%0d_cs_len", i),  64'(fr_len[bf]),       64'd168);
      check($sformatf("v%0d_rxv_cnt", i), 64'(rxv_cnt - brx),    64'(vecs[i].exp_rxv));
      check($sformatf("v%0d_rx_data", i), 64'(rx_data),          64'(vecs[i].exp_rx));
      check($sformatf("v%0d_setup", i),   64'(fr_fall_cyc[bf] - pop_cyc[bp]), 64'd3);
    end

    // Two words queued back-to-back
    bf  = frames;
    bp  = pops;
    brx = rxv_cnt;
    slave_resp = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    push(41'h1_5A_0F0F0F0F);
    push(41'h0_C3_FFFFFFFF);
    wait_frames(bf + 2, 900, "b2b_frames_done");
    @(negedge clk);
    check("b2b_pops",        64'(pops - bp), 64'd2);
    check("b2b_pop_to_pop",  64'(pop_cyc[bp + 1] - pop_cyc[bp]), 64'(171 + EXP_GAP));
    check("b2b_pop_vs_rise", 64'(pop_cyc[bp + 1] - fr_rise_cyc[bf]), 64'(EXP_GAP));
    check("b2b_cs_high_gap", 64'(fr_fall_cyc[bf + 1] - fr_rise_cyc[bf]), 64'(3 + EXP_GAP));
    check("b2b_mosi0",       64'(fr_mosi[bf]),     64'(41'h1_5A_0F0F0F0F));
    check("b2b_mosi1",       64'(fr_mosi[bf + 1]), 64'(41'h0_C3_00000000));
    check("b2b_len1",        64'(fr_len[bf + 1]),  64'd168);
    check("b2b_rxv_cnt",     64'(rxv_cnt - brx),   64'd1);
    check("b2b_rx_data",     64'(rx_data),         64'hCAFEF00D);

    // Reset pulse after 20 rising SCLK edges of a read frame
    bf  = frames;
    bp  = pops;
    brx = rxv_cnt;
    slave_resp = 32'h55AA55AA;
    @(posedge clk);
    #1 push(41'h0_42_00000000);
    k = 0;
    while (!(spi_cs_n === 1'b0 && rise_cnt_cur >= 20) && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("rst_mid_reached_bit20", 64'(rise_cnt_cur >= 20), 64'd1);
    @(negedge clk);
    check("rst_mid_busy_before", 64'(busy),     64'd1);
    check("rst_mid_cs_before",   64'(spi_cs_n), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_cs_n",     64'(spi_cs_n),   64'd1);
    check("rst_mid_sclk",     64'(spi_sclk),   64'd0);
    check("rst_mid_busy",     64'(busy),       64'd0);
    check("rst_mid_mosi",     64'(spi_mosi),   64'd0);
    check("rst_mid_rx_valid", 64'(rx_valid),   64'd0);
    check("rst_mid_rx_data",  64'(rx_data),    64'd0);
    repeat (20) @(negedge clk);
    check("rst_mid_no_reread", 64'(pops - bp),    64'd1);
    check("rst_mid_no_rxv",    64'(rxv_cnt - brx), 64'd0);
    check("rst_mid_idle",      64'(busy),          64'd0);

    slave_resp = 32'h0BADC0DE;
    @(posedge clk);
    #1 push(41'h0_99_00000000);
    wait_frames(bf + 2, 400, "post_rst_frame_done");
    @(negedge clk);
    check("post_rst_pops",    64'(pops - bp),       64'd2);
    check("post_rst_mosi",    64'(fr_mosi[bf + 1]), 64'(41'h0_99_00000000));
    check("post_rst_rises",   64'(fr_rises[bf + 1]), 64'd41);
    check("post_rst_cs_len",  64'(fr_len[bf + 1]),  64'd168);
    check("post_rst_rxv_cnt", 64'(rxv_cnt - brx),   64'd1);
    check("post_rst_rx_data", 64'(rx_data),         64'h0BADC0DE);

    check("rx_valid_with_cs_rise", 64'(rxv_bad_align), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
